// File: rtl/edge_arb_pkg.sv
// Shared definitions for the edge event arbiter: default sizing, ID width
// helper and a round-robin first-set-bit search usable by other arbiters.
package edge_arb_pkg;

  // Default channel count when the top is instantiated without override.
  localparam int N_CH_DEFAULT = 4;

  // Widest request vector the round-robin helper supports.
  localparam int RR_MAX = 16;

  // Result of a round-robin search: whether any request was found and where.
  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_grant_t;

  // Channel index width for a given channel count (never below one bit).
  function automatic int calc_id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of req[n-1:0], searching ptr, ptr+1, ... and wrapping at n.
  // ptr must be below n; bits at or above n are ignored.
  function automatic rr_grant_t rr_first(input logic [RR_MAX-1:0] req,
                                         input logic [3:0] ptr,
                                         input int n);
    rr_grant_t r;
    int        c;
    r = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      c = int'(ptr) + k;
      if (c >= n) c = c - n;
      if (k < n && !r.found && req[c[3:0]]) begin
        r.found = 1'b1;
        r.idx   = c[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_capture_cell.sv
// One channel of edge capture: previous-sample register, pending flag and
// sticky overflow flag.
module edge_capture_cell
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  input  logic consume,
  input  logic ovf_clr,
  output logic pending,
  output logic ovf
);

  logic prev_reg;
  logic pending_reg;
  logic ovf_reg;
  logic rise;
  logic ovf_set;

  assign rise    = sig_in & ~prev_reg;
  // A new edge while still pending is an overflow unless the old event is
  // being consumed in the same cycle (then the new one simply replaces it).
  assign ovf_set = rise & pending_reg & ~consume;

  // Capture state; reset loads prev from the line so a held-high input is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg    <= sig_in;
      pending_reg <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      prev_reg    <= sig_in;
      pending_reg <= (pending_reg & ~consume) | rise;
      ovf_reg     <= ovf_set | (ovf_reg & ~ovf_clr);
    end
  end

  assign pending = pending_reg;
  assign ovf     = ovf_reg;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge capture with a round-robin scheduler presenting
// one event at a time on a valid/ready interface.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter  int N_CH = N_CH_DEFAULT,
  localparam int ID_W = calc_id_w(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sig_in,
  input  logic [N_CH-1:0] en,
  input  logic            evt_ready,
  input  logic [N_CH-1:0] ovf_clr,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] ovf
);

  logic            evt_valid_reg, evt_valid_next;
  logic [ID_W-1:0] evt_id_reg, evt_id_next;
  logic [ID_W-1:0] ptr_reg, ptr_next;
  logic [N_CH-1:0] consume;
  logic [N_CH-1:0] cand;
  logic            load;
  rr_grant_t       grant;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign consume[gi] = evt_valid_reg & evt_ready & (evt_id_reg == ID_W'(gi));

      edge_capture_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .sig_in  (sig_in[gi]),
        .consume (consume[gi]),
        .ovf_clr (ovf_clr[gi]),
        .pending (pending[gi]),
        .ovf     (ovf[gi])
      );
    end
  endgenerate

  // The channel being consumed this cycle is excluded so it is not re-issued
  // from stale pending state.
  assign cand = pending & en & ~consume;
  assign load = ~evt_valid_reg | (evt_valid_reg & evt_ready);

  // Next output and pointer: reload only when idle or on a handshake.
  always_comb begin
    evt_valid_next = evt_valid_reg;
    evt_id_next    = evt_id_reg;
    ptr_next       = ptr_reg;
    grant          = rr_first(RR_MAX'(cand), 4'(ptr_reg), N_CH);
    if (load) begin
      if (grant.found) begin
        evt_valid_next = 1'b1;
        evt_id_next    = ID_W'(grant.idx);
        if (int'(grant.idx) == N_CH - 1) begin
          ptr_next = '0;
        end else begin
          ptr_next = ID_W'(grant.idx + 4'd1);
        end
      end else begin
        evt_valid_next = 1'b0;
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_reg <= 1'b0;
      evt_id_reg    <= '0;
      ptr_reg       <= '0;
    end else begin
      evt_valid_reg <= evt_valid_next;
      evt_id_reg    <= evt_id_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign evt_valid = evt_valid_reg;
  assign evt_id    = evt_id_reg;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed scenarios followed by
// random traffic, all compared each cycle against a behavioural model.
module tb_edge_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sig_in;
  logic [N-1:0] en;
  logic         evt_ready;
  logic [N-1:0] ovf_clr;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic [N-1:0] pending;
  logic [N-1:0] ovf;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit [N-1:0] m_prev, m_pend, m_ovf;
  bit         m_valid;
  int         m_id, m_ptr;

  edge_event_arbiter #(.N_CH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .en        (en),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .pending   (pending),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: model computes the post-edge state from the spec rules,
  // then the DUT is compared just after the edge.
  task automatic tick();
    bit [N-1:0] np, no, cand;
    bit         nv, found;
    int         nid, nptr, c;
    bit         rise_i, cons_i;
    np = '0; no = '0; cand = '0;
    nv = m_valid; nid = m_id; nptr = m_ptr; found = 0;
    if (rst) begin
      np = '0; no = '0; nv = 0; nid = 0; nptr = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        rise_i  = sig_in[i] && !m_prev[i];
        cons_i  = m_valid && evt_ready && (m_id == i);
        np[i]   = (m_pend[i] && !cons_i) || rise_i;
        no[i]   = (rise_i && m_pend[i] && !cons_i) || (m_ovf[i] && !ovf_clr[i]);
        cand[i] = m_pend[i] && en[i] && !cons_i;
      end
      if (!m_valid || evt_ready) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!found && cand[c]) begin
            found = 1; nid = c; nptr = (c + 1) % N;
          end
        end
        nv = found;
      end
    end
    @(posedge clk);
    m_prev = sig_in; m_pend = np; m_ovf = no;
    m_valid = nv; m_id = nid; m_ptr = nptr;
    #1;
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    chk("evt_id",    32'(evt_id),    32'(m_id));
    chk("pending",   32'(pending),   32'(m_pend));
    chk("ovf",       32'(ovf),       32'(m_ovf));
  endtask

  initial begin
    int exp_seq[4];
    rst = 1'b1; sig_in = 4'hF; en = 4'hF; evt_ready = 1'b0; ovf_clr = '0;
    m_prev = '0; m_pend = '0; m_ovf = '0; m_valid = 0; m_id = 0; m_ptr = 0;
    tick(); tick();
    chk("reset_valid", 32'(evt_valid), 32'd0);
    chk("reset_id", 32'(evt_id), 32'd0);

    // 1: line held high through reset gives no event
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_high_valid", 32'(evt_valid), 32'd0);
      chk("held_high_pend", 32'(pending), 32'd0);
    end

    // 2: single edge latency
    sig_in = 4'h0; tick();
    evt_ready = 1'b1; sig_in = 4'b0100; tick();
    chk("lat_pend_k", 32'(pending[2]), 32'd1);
    chk("lat_valid_k", 32'(evt_valid), 32'd0);
    tick();
    chk("lat_valid_k1", 32'(evt_valid), 32'd1);
    chk("lat_id_k1", 32'(evt_id), 32'd2);
    tick();
    chk("lat_pend_k2", 32'(pending[2]), 32'd0);
    chk("lat_valid_k2", 32'(evt_valid), 32'd0);

    // 3: all channels at once from ptr=0, back-to-back
    rst = 1'b1; sig_in = 4'h0; tick(); rst = 1'b0;
    sig_in = 4'hF; tick();
    exp_seq = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr0_valid", 32'(evt_valid), 32'd1);
      chk("rr0_id", 32'(evt_id), 32'(exp_seq[i]));
    end
    tick();
    chk("rr0_idle", 32'(evt_valid), 32'd0);
    // grant channel 1 to move ptr to 2, then all channels again
    sig_in = 4'h0; tick();
    sig_in = 4'b0010; tick(); tick(); tick();
    sig_in = 4'h0; tick();
    sig_in = 4'hF; tick();
    exp_seq = '{2, 3, 0, 1};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr2_id", 32'(evt_id), 32'(exp_seq[i]));
    end
    tick();

    // 4: overflow while stalled, clear, and set-wins-over-clear
    evt_ready = 1'b0;
    sig_in = 4'h0; tick();
    sig_in = 4'b0010; tick(); tick();
    chk("ovf_present_id", 32'(evt_id), 32'd1);
    sig_in = 4'h0; tick();
    sig_in = 4'b0010; tick();
    chk("ovf_set", 32'(ovf[1]), 32'd1);
    chk("ovf_hold_id", 32'(evt_id), 32'd1);
    ovf_clr = 4'b0010; tick(); ovf_clr = '0;
    chk("ovf_clr", 32'(ovf[1]), 32'd0);
    sig_in = 4'h0; tick();
    sig_in = 4'b0010; ovf_clr = 4'b0010; tick(); ovf_clr = '0;
    chk("ovf_set_wins", 32'(ovf[1]), 32'd1);
    ovf_clr = 4'b0010; evt_ready = 1'b1; tick(); ovf_clr = '0;
    tick();

    // 5: consume and new edge on the same channel
    evt_ready = 1'b0;
    sig_in = 4'h0; tick();
    sig_in = 4'b1000; tick(); tick();
    chk("c5_present", 32'(evt_id), 32'd3);
    sig_in = 4'h0; tick();
    sig_in = 4'b1000; evt_ready = 1'b1; tick();
    chk("c5_ovf", 32'(ovf[3]), 32'd0);
    chk("c5_pend", 32'(pending[3]), 32'd1);
    tick();
    chk("c5_repres_valid", 32'(evt_valid), 32'd1);
    chk("c5_repres_id", 32'(evt_id), 32'd3);
    tick(); tick();

    // 6: enable masking, then reset mid-operation
    evt_ready = 1'b0; en = 4'b1011;
    sig_in = 4'h0; tick();
    sig_in = 4'b1100; tick(); tick();
    chk("en_grant3", 32'(evt_id), 32'd3);
    evt_ready = 1'b1; tick(); tick();
    chk("en_pend2", 32'(pending[2]), 32'd1);
    chk("en_idle", 32'(evt_valid), 32'd0);
    en = 4'hF; tick();
    chk("en_grant2", 32'(evt_id), 32'd2);
    tick();
    evt_ready = 1'b0; sig_in = 4'h0; tick();
    sig_in = 4'b0101; tick();
    chk("pre_rst_pend", 32'(pending), 32'b0101);
    rst = 1'b1; tick();
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    rst = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      sig_in    = 4'($urandom);
      en        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      evt_ready = 1'($urandom);
      ovf_clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      rst       = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
